// File: rtl/hx711_axi_slave.sv
// HX711 24-bit load-cell ADC reader with an AXI4-Lite register front end.
// Latency: writes land on the handshake edge (bvalid one cycle later); reads are registered one cycle after arready.
// Backpressure: no new write while bvalid waits for bready, no new read while rvalid waits for rready.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   sole clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*            AXI4-Lite write channels (OKAY-only responses)
//   s00_axi_ar* / r*                 AXI4-Lite read channels (OKAY-only responses)
//   hx711_dout                       asynchronous data/ready line from the HX711
//   hx711_pd_sck                     serial clock to the HX711, high only while shifting a bit
//
// Register map (byte address, bits [3:2] select):
//   0x0 CTRL    RW  bit0 enable, bits[2:1] gain select
//   0x4 STATUS  RO  bit0 valid, bit1 busy, bit2 overrun
//   0x8 DATA    RO  last sample, sign-extended to 32 bits
//   0xC SCRATCH RW  32 bits
// CLK_DIV is the PD_SCK half-period in clock cycles, usable from 4 to 1000.

module hx711_axi_slave #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int CLK_DIV              = 50
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic                                hx711_dout,
    output logic                                hx711_pd_sck
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_SCK_HI   = 3'd2;
    localparam logic [2:0] S_SCK_LO   = 3'd3;
    localparam logic [2:0] S_LATCH    = 3'd4;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DATA    = 2'd2;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                            ctrl_en;
    logic [1:0]                      ctrl_gain;
    logic [C_S00_AXI_DATA_WIDTH-1:0] scratch;
    logic [C_S00_AXI_DATA_WIDTH-1:0] data_reg;
    logic                            st_valid;
    logic                            st_overrun;
    logic                            busy;

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       pulse_cnt;
    logic [4:0]       n_pulses;
    logic [4:0]       n_sel;
    logic [23:0]      shift_reg;
    logic             dout_meta;
    logic             dout_sync;
    logic             div_last;

    // ------------------------------------------------------------------
    // AXI handshake state
    // ------------------------------------------------------------------
    logic aw_rdy;
    logic ar_rdy;
    logic wr_fire;
    logic rd_fire;
    logic rd_is_data;
    logic data_rd_done;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rd_mux;

    assign s00_axi_awready = aw_rdy;
    assign s00_axi_wready  = aw_rdy;
    assign s00_axi_arready = ar_rdy;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rresp   = 2'b00;

    // awready/wready are only raised with both valids present, so the
    // handshake edge is simply aw_rdy sampled high with awvalid.
    assign wr_fire      = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire      = ar_rdy & s00_axi_arvalid;
    assign data_rd_done = s00_axi_rvalid & s00_axi_rready & rd_is_data;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_rdy         <= 1'b0;
            s00_axi_bvalid <= 1'b0;
        end else begin
            aw_rdy <= ~aw_rdy & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
            if (wr_fire) begin
                s00_axi_bvalid <= 1'b1;
            end else if (s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // CTRL and SCRATCH are the only writable registers; STATUS/DATA writes
    // complete normally but change nothing.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_en   <= 1'b0;
            ctrl_gain <= 2'b00;
            scratch   <= '0;
        end else if (wr_fire) begin
            case (s00_axi_awaddr[3:2])
                A_CTRL: begin
                    if (s00_axi_wstrb[0]) begin
                        ctrl_en   <= s00_axi_wdata[0];
                        ctrl_gain <= s00_axi_wdata[2:1];
                    end
                end
                A_STATUS, A_DATA: ;
                default: begin
                    for (int i = 0; i < C_S00_AXI_DATA_WIDTH/8; i++) begin
                        if (s00_axi_wstrb[i]) begin
                            scratch[i*8 +: 8] <= s00_axi_wdata[i*8 +: 8];
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (s00_axi_araddr[3:2])
            A_CTRL:   rd_mux[2:0] = {ctrl_gain, ctrl_en};
            A_STATUS: rd_mux[2:0] = {st_overrun, busy, st_valid};
            A_DATA:   rd_mux      = data_reg;
            default:  rd_mux      = scratch;
        endcase
    end

    // rdata is captured from the pre-edge register values, so a write
    // accepted on the same edge is not visible to this read.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ar_rdy         <= 1'b0;
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            rd_is_data     <= 1'b0;
        end else begin
            ar_rdy <= ~ar_rdy & s00_axi_arvalid & ~s00_axi_rvalid;
            if (rd_fire) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
                rd_is_data     <= (s00_axi_araddr[3:2] == A_DATA);
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // DOUT synchroniser; idles high so a fresh reset never looks "ready".
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            dout_meta <= 1'b1;
            dout_sync <= 1'b1;
        end else begin
            dout_meta <= hx711_dout;
            dout_sync <= dout_meta;
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    // Total pulses per frame: 24 data bits plus 1..3 that pick the next
    // conversion's channel/gain.
    always_comb begin
        case (ctrl_gain)
            2'b01:   n_sel = 5'd26;
            2'b10:   n_sel = 5'd27;
            default: n_sel = 5'd25;
        endcase
    end

    assign div_last     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign busy         = (state == S_SCK_HI) || (state == S_SCK_LO) || (state == S_LATCH);
    // Decoded straight from state so a reset drops the clock line immediately.
    assign hx711_pd_sck = (state == S_SCK_HI);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            pulse_cnt <= 5'd0;
            n_pulses  <= 5'd0;
            shift_reg <= 24'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_en) begin
                        state <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    // Gain is sampled until the frame starts, then frozen.
                    n_pulses  <= n_sel;
                    div_cnt   <= '0;
                    pulse_cnt <= 5'd0;
                    if (!ctrl_en) begin
                        state <= S_IDLE;
                    end else if (!dout_sync) begin
                        state     <= S_SCK_HI;
                        pulse_cnt <= 5'd1;
                    end
                end
                S_SCK_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        state   <= S_SCK_LO;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_SCK_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        // Sample at the end of the low phase, long after the
                        // HX711 has moved DOUT on the rising edge.
                        if (pulse_cnt <= 5'd24) begin
                            shift_reg <= {shift_reg[22:0], dout_sync};
                        end
                        if (pulse_cnt == n_pulses) begin
                            state <= S_LATCH;
                        end else begin
                            state     <= S_SCK_HI;
                            pulse_cnt <= pulse_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_LATCH: begin
                    pulse_cnt <= 5'd0;
                    state     <= ctrl_en ? S_WAIT_RDY : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample and status flags. A frame landing on the same edge as a DATA
    // read keeps the new sample flagged valid.
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            data_reg   <= '0;
            st_valid   <= 1'b0;
            st_overrun <= 1'b0;
        end else if (state == S_LATCH) begin
            data_reg   <= {{(C_S00_AXI_DATA_WIDTH-24){shift_reg[23]}}, shift_reg};
            st_valid   <= 1'b1;
            st_overrun <= st_overrun | st_valid;
        end else if (data_rd_done) begin
            st_valid   <= 1'b0;
            st_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hx711_axi_slave.sv
`timescale 1ns/1ps
module tb_hx711_axi_slave;

    localparam int CLK_DIV = 50;

    logic        s00_axi_aclk = 1'b0;
    logic        s00_axi_aresetn = 1'b0;
    logic [3:0]  s00_axi_awaddr = '0;
    logic [2:0]  s00_axi_awprot = '0;
    logic        s00_axi_awvalid = 1'b0;
    logic        s00_axi_awready;
    logic [31:0] s00_axi_wdata = '0;
    logic [3:0]  s00_axi_wstrb = '0;
    logic        s00_axi_wvalid = 1'b0;
    logic        s00_axi_wready;
    logic [1:0]  s00_axi_bresp;
    logic        s00_axi_bvalid;
    logic        s00_axi_bready = 1'b0;
    logic [3:0]  s00_axi_araddr = '0;
    logic [2:0]  s00_axi_arprot = '0;
    logic        s00_axi_arvalid = 1'b0;
    logic        s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic [1:0]  s00_axi_rresp;
    logic        s00_axi_rvalid;
    logic        s00_axi_rready = 1'b0;
    logic        hx711_dout = 1'b1;
    logic        hx711_pd_sck;

    int checks = 0;
    int errors = 0;

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    hx711_axi_slave #(
        .C_S00_AXI_DATA_WIDTH(32),
        .C_S00_AXI_ADDR_WIDTH(4),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .s00_axi_aclk(s00_axi_aclk),
        .s00_axi_aresetn(s00_axi_aresetn),
        .s00_axi_awaddr(s00_axi_awaddr),
        .s00_axi_awprot(s00_axi_awprot),
        .s00_axi_awvalid(s00_axi_awvalid),
        .s00_axi_awready(s00_axi_awready),
        .s00_axi_wdata(s00_axi_wdata),
        .s00_axi_wstrb(s00_axi_wstrb),
        .s00_axi_wvalid(s00_axi_wvalid),
        .s00_axi_wready(s00_axi_wready),
        .s00_axi_bresp(s00_axi_bresp),
        .s00_axi_bvalid(s00_axi_bvalid),
        .s00_axi_bready(s00_axi_bready),
        .s00_axi_araddr(s00_axi_araddr),
        .s00_axi_arprot(s00_axi_arprot),
        .s00_axi_arvalid(s00_axi_arvalid),
        .s00_axi_arready(s00_axi_arready),
        .s00_axi_rdata(s00_axi_rdata),
        .s00_axi_rresp(s00_axi_rresp),
        .s00_axi_rvalid(s00_axi_rvalid),
        .s00_axi_rready(s00_axi_rready),
        .hx711_dout(hx711_dout),
        .hx711_pd_sck(hx711_pd_sck)
    );

    // ------------------------------------------------------------------
    // HX711 model: pulls DOUT low when armed, then shifts the armed value
    // out MSB first on each PD_SCK rising edge; DOUT returns high after bit 24.
    // Also counts pulses and high-phase widths (in clock cycles).
    // ------------------------------------------------------------------
    logic [23:0] arm_val = '0;
    int          arm_seq = 0;
    int          seen_seq = 0;
    logic [23:0] cur_val = '0;
    int          edges = 0;
    int          pulses = 0;
    int          bad_w = 0;
    int          hi_cyc = 0;
    logic        sck_q = 1'b0;

    always @(negedge s00_axi_aclk) begin
        if (arm_seq != seen_seq) begin
            seen_seq   = arm_seq;
            cur_val    = arm_val;
            edges      = 0;
            hx711_dout = 1'b0;
        end else if (hx711_pd_sck && !sck_q) begin
            edges++;
            pulses++;
            hi_cyc = 1;
            hx711_dout = (edges <= 24) ? cur_val[24-edges] : 1'b1;
        end else if (hx711_pd_sck) begin
            hi_cyc++;
        end
        if (!hx711_pd_sck && sck_q && hi_cyc != CLK_DIV) bad_w++;
        sck_q = hx711_pd_sck;
    end

    task automatic arm(input logic [23:0] v);
        @(negedge s00_axi_aclk);
        arm_val = v;
        arm_seq++;
    endtask

    // ------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        @(negedge s00_axi_aclk);
        s00_axi_awaddr = a; s00_axi_wdata = d; s00_axi_wstrb = s;
        s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge s00_axi_aclk); n++; end
        while (!(s00_axi_awready && s00_axi_wready) && n < 20);
        checks++;
        if (!(s00_axi_awready && s00_axi_wready)) begin
            errors++;
            $display("FAIL aw_accept addr=%h awready=%b wready=%b required 1/1", a, s00_axi_awready, s00_axi_wready);
        end
        @(negedge s00_axi_aclk);
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
        n = 0;
        while (!s00_axi_bvalid && n < 20) begin @(negedge s00_axi_aclk); n++; end
        checks++;
        if (!s00_axi_bvalid) begin
            errors++;
            $display("FAIL bvalid addr=%h got 0 required 1", a);
        end
        resp = s00_axi_bresp;
        s00_axi_bready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge s00_axi_aclk);
        s00_axi_araddr = a; s00_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge s00_axi_aclk); n++; end
        while (!s00_axi_arready && n < 20);
        checks++;
        if (!s00_axi_arready) begin
            errors++;
            $display("FAIL ar_accept addr=%h arready=0 required 1", a);
        end
        @(negedge s00_axi_aclk);
        s00_axi_arvalid = 1'b0;
        n = 0;
        while (!s00_axi_rvalid && n < 20) begin @(negedge s00_axi_aclk); n++; end
        checks++;
        if (!s00_axi_rvalid) begin
            errors++;
            $display("FAIL rvalid addr=%h got 0 required 1", a);
        end
        d = s00_axi_rdata;
        resp = s00_axi_rresp;
        s00_axi_rready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_rready = 1'b0;
    endtask

    // Waits until the model has seen n more pulses than base, then lets the
    // low phase, LATCH and any stray extra pulse play out.
    task automatic wait_frame(input int base, input int n);
        int k;
        k = 0;
        while ((pulses - base) < n && k < 10000) begin @(negedge s00_axi_aclk); k++; end
        checks++;
        if ((pulses - base) < n) begin
            errors++;
            $display("FAIL frame_timeout pulses=%0d required %0d", pulses - base, n);
        end
        repeat (3*CLK_DIV) @(negedge s00_axi_aclk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        s00_axi_aresetn = 1'b0;
        s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_arvalid = 1'b1;
        s00_axi_bready = 1'b1; s00_axi_rready = 1'b1;
        repeat (4) @(negedge s00_axi_aclk);
        checks++;
        if ({s00_axi_awready, s00_axi_wready, s00_axi_bvalid, s00_axi_arready, s00_axi_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake got %b required 00000",
                     {s00_axi_awready, s00_axi_wready, s00_axi_bvalid, s00_axi_arready, s00_axi_rvalid});
        end
        checks++;
        if (s00_axi_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h required 00000000", s00_axi_rdata);
        end
        checks++;
        if ({s00_axi_bresp, s00_axi_rresp} !== 4'b0) begin
            errors++; $display("FAIL reset_resp got %b required 0000", {s00_axi_bresp, s00_axi_rresp});
        end
        checks++;
        if (hx711_pd_sck !== 1'b0) begin
            errors++; $display("FAIL reset_pd_sck got %b required 0", hx711_pd_sck);
        end
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_arvalid = 1'b0;
        s00_axi_bready = 1'b0; s00_axi_rready = 1'b0;
        @(negedge s00_axi_aclk);
        s00_axi_aresetn = 1'b1;
        repeat (2) @(negedge s00_axi_aclk);
    endtask

    task automatic test_regmap;
        logic [31:0] wv [4];
        logic [31:0] exp_r [4];
        logic [31:0] d;
        logic [1:0]  r;
        wv    = '{32'h1, 32'h2, 32'h3, 32'h4};
        exp_r = '{32'h1, 32'h0, 32'h0, 32'h4};
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i*4), wv[i], 4'hF, r);
            checks++;
            if (r !== 2'b00) begin
                errors++; $display("FAIL regmap_bresp[%0d] got %b required 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i*4), d, r);
            checks++;
            if (d !== exp_r[i] || r !== 2'b00) begin
                errors++;
                $display("FAIL regmap_read[%0d] got %h/%b required %h/00", i, d, r, exp_r[i]);
            end
        end
    endtask

    task automatic test_wstrb;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'hC, 32'hAABBCCDD, 4'b0101, r);
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'h00BB00DD) begin
            errors++; $display("FAIL wstrb_scratch got %h required 00bb00dd", d);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        axi_write(4'hC, 32'h11111111, 4'hF, r);
        @(negedge s00_axi_aclk);
        s00_axi_awaddr = 4'hC; s00_axi_wdata = 32'h22222222; s00_axi_wstrb = 4'hF;
        s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
        s00_axi_araddr = 4'hC; s00_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge s00_axi_aclk); n++; end
        while (!(s00_axi_awready && s00_axi_arready) && n < 20);
        checks++;
        if (!(s00_axi_awready && s00_axi_arready)) begin
            errors++;
            $display("FAIL simul_accept awready=%b arready=%b required 1/1", s00_axi_awready, s00_axi_arready);
        end
        @(negedge s00_axi_aclk);
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_arvalid = 1'b0;
        checks++;
        if (!(s00_axi_bvalid && s00_axi_rvalid) || s00_axi_rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL simul_read bvalid=%b rvalid=%b rdata=%h required 1/1/11111111",
                     s00_axi_bvalid, s00_axi_rvalid, s00_axi_rdata);
        end
        s00_axi_bready = 1'b1; s00_axi_rready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_bready = 1'b0; s00_axi_rready = 1'b0;
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'h22222222) begin
            errors++; $display("FAIL simul_after got %h required 22222222", d);
        end
    endtask

    task automatic test_bresp_hold;
        logic [31:0] d;
        logic [1:0]  r;
        int n, aw_seen, bv_low;
        @(negedge s00_axi_aclk);
        s00_axi_awaddr = 4'hC; s00_axi_wdata = 32'hAAAA0000; s00_axi_wstrb = 4'hF;
        s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge s00_axi_aclk); n++; end
        while (!s00_axi_awready && n < 20);
        @(negedge s00_axi_aclk);
        // Keep offering a second write while the response is not taken.
        s00_axi_wdata = 32'hBBBB0000;
        aw_seen = 0; bv_low = 0;
        repeat (6) begin
            @(negedge s00_axi_aclk);
            if (s00_axi_awready) aw_seen++;
            if (!s00_axi_bvalid) bv_low++;
        end
        checks++;
        if (aw_seen != 0 || bv_low != 0) begin
            errors++;
            $display("FAIL bresp_hold awready_cycles=%0d bvalid_low_cycles=%0d required 0/0", aw_seen, bv_low);
        end
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
        s00_axi_bready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_bready = 1'b0;
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'hAAAA0000) begin
            errors++; $display("FAIL bresp_hold_data got %h required aaaa0000", d);
        end
    endtask

    task automatic test_frame_gain0;
        logic [31:0] d;
        logic [1:0]  r;
        int base, bw, k;
        axi_write(4'h0, 32'h1, 4'hF, r);
        base = pulses; bw = bad_w;
        arm(24'h800001);
        k = 0;
        while ((pulses - base) < 3 && k < 2000) begin @(negedge s00_axi_aclk); k++; end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("FAIL busy_status got %h required 00000002", d);
        end
        wait_frame(base, 25);
        checks++;
        if (pulses - base != 25) begin
            errors++; $display("FAIL gain0_pulses got %0d required 25", pulses - base);
        end
        checks++;
        if (bad_w - bw != 0) begin
            errors++; $display("FAIL gain0_high_width bad_pulses=%0d required 0", bad_w - bw);
        end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL gain0_status got %h required 00000001", d);
        end
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'hFF800001) begin
            errors++; $display("FAIL gain0_data got %h required ff800001", d);
        end
    endtask

    task automatic test_frame_gain1;
        logic [31:0] d;
        logic [1:0]  r;
        int base;
        axi_write(4'h0, 32'h3, 4'hF, r);
        base = pulses;
        arm(24'h123456);
        wait_frame(base, 26);
        checks++;
        if (pulses - base != 26) begin
            errors++; $display("FAIL gain1_pulses got %0d required 26", pulses - base);
        end
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h00123456) begin
            errors++; $display("FAIL gain1_data got %h required 00123456", d);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        logic [1:0]  r;
        int base;
        axi_write(4'h0, 32'h1, 4'hF, r);
        base = pulses;
        arm(24'h000111);
        wait_frame(base, 25);
        base = pulses;
        arm(24'h7FFFFF);
        wait_frame(base, 25);
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h5) begin
            errors++; $display("FAIL overrun_status got %h required 00000005", d);
        end
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h007FFFFF) begin
            errors++; $display("FAIL overrun_data got %h required 007fffff", d);
        end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL overrun_cleared got %h required 00000000", d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        logic [1:0]  r;
        int base, k;
        axi_write(4'hC, 32'hDEADBEEF, 4'hF, r);
        base = pulses;
        arm(24'hABCDEF);
        k = 0;
        while (!((pulses - base) >= 10 && hx711_pd_sck) && k < 5000) begin
            @(negedge s00_axi_aclk); k++;
        end
        s00_axi_aresetn = 1'b0;
        #1;
        checks++;
        if (hx711_pd_sck !== 1'b0 || (pulses - base) != 10) begin
            errors++;
            $display("FAIL reset_mid_sck pd_sck=%b at_pulse=%0d required 0 at 10", hx711_pd_sck, pulses - base);
        end
        repeat (3) @(negedge s00_axi_aclk);
        s00_axi_aresetn = 1'b1;
        repeat (2) @(negedge s00_axi_aclk);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i*4), d, r);
            checks++;
            if (d !== 32'h0) begin
                errors++; $display("FAIL reset_mid_reg[%0d] got %h required 00000000", i, d);
            end
        end
    endtask

    initial begin
        test_reset;
        test_regmap;
        test_wstrb;
        test_simultaneous;
        test_bresp_hold;
        test_frame_gain0;
        test_frame_gain1;
        test_overrun;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
